next_pc_unit: RTL and testbench
===============================

Name: next_pc_unit

Overview:
- Parametrised successor to the fixed "+4 or branch offset" next-PC select; owns the program counter register.
- Resolves all six RV32I conditional branches plus JAL/JALR from the fetched instruction, ALU compare flags and rs1.
- Raises a one-cycle pipeline flush on every redirect; traps (sticky halt) on a misaligned target.
- Sits between instruction fetch and the ALU/register file in the single-issue core.

Parameters:
XLEN, 32, datapath/PC width (32 or 64)
RESET_VECTOR, 0, PC value loaded on reset
IALIGN, 32, instruction alignment in bits; 32 requires target[1:0]==0, 16 requires target[0]==0

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  1 = advance PC this cycle, 0 = stall (hold all state)
instr  in  32  instruction currently in execute
zero  in  1  ALU flag, 1 when rs1 == rs2
lt  in  1  ALU flag, signed rs1 < rs2
ltu  in  1  ALU flag, unsigned rs1 < rs2
rs1  in  XLEN  rs1 operand, used by JALR
pc  out  XLEN  current PC (registered)
pc_plus4  out  XLEN  pc+4 modulo 2^XLEN (link value for JAL/JALR)
taken  out  1  combinational: current instr redirects control flow
flush  out  1  registered: 1 for exactly one cycle after an accepted redirect
misaligned  out  1  sticky trap flag
branch_cnt  out  32  branches retired (see Optional Feature)
taken_cnt  out  32  branches taken (see Optional Feature)

Behaviour:
- Reset (rst=1 at clock edge, priority over en): pc=RESET_VECTOR, flush=0, misaligned=0, state=RUN, counters=0.
- Decode, opcode = instr[6:0]:
  - 1100011 branch, by funct3:
    - 000 BEQ: zero
    - 001 BNE: !zero
    - 100 BLT: lt
    - 101 BGE: !lt
    - 110 BLTU: ltu
    - 111 BGEU: !ltu
    - 010/011: never taken
  - 1101111 JAL: always taken.
  - 1100111 JALR: always taken.
  - Any other opcode: not taken.
- Immediates, sign-extended from instr[31] to XLEN:
  - B-imm = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - J-imm = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - I-imm = instr[31:20]
- Targets (all additions wrap modulo 2^XLEN):
  - branch: pc + B-imm
  - JAL: pc + J-imm
  - JALR: (rs1 + I-imm) with bit0 cleared
- Misaligned target = taken and the target violates IALIGN. Evaluated only when taken=1; a not-taken branch to a bad target is not a trap.
- FSM states: RUN, TRAP.
  - RUN, en=0: hold pc; flush cleared to 0.
  - RUN, en=1, not taken: pc <= pc_plus4; flush <= 0.
  - RUN, en=1, taken, aligned: pc <= target; flush <= 1.
  - RUN, en=1, taken, misaligned: pc held; misaligned <= 1; flush <= 0; go to TRAP.
  - TRAP: pc, misaligned=1 held regardless of en/instr; taken still reflects decode; flush=0; leave only via rst.
- Latency: new pc visible the cycle after the accepting edge. flush rises in that same cycle.
- Back-to-back taken redirects keep flush high on consecutive cycles.
- Stall during flush: the flush pulse still ends after one cycle.

Optional Feature:
- Macro: NEXT_PC_STATS_EN.
- Defined:
  - branch_cnt increments on each en=1 RUN cycle with opcode 1100011.
  - taken_cnt increments when that branch is also taken.
  - Both counters are 32-bit, wrap at 2^32 and are cleared by rst.
  - JAL/JALR are not counted.
- Undefined: both ports remain present, driven constant 0, and no counter flops are synthesised.

Test Plan:
- rst=1 for 2 cycles with RESET_VECTOR=0x100 -> pc=0x100, flush=0, misaligned=0. Then en=1 with addi -> pc=0x104, 0x108 on successive cycles.
- pc=0x200, BEQ with offset -8 (instr=0xFE000CE3), zero=1 -> taken=1, next pc=0x1F8, flush=1 for one cycle. Same with zero=0 -> pc=0x204, flush=0.
- pc=0x300, BLTU +16 with ltu=1 and lt=0 -> pc=0x310. BGE +16 with lt=1 -> pc=0x304.
- JALR rs1=0x1001, I-imm=+2 -> pc=0x1002, pc_plus4 (before the edge) = old pc+4. Then JALR rs1=0x1000, I-imm=+2 with IALIGN=32 -> misaligned=1, pc held. Further en=1 cycles keep pc held; only rst clears the trap.
- en=0 with a taken BNE presented -> pc and flush unchanged. Raise en -> redirect occurs. Also: pc=0xFFFFFFFC with en=1, non-branch -> pc wraps to 0x0.
- NEXT_PC_STATS_EN defined, 5 branches (3 taken) plus 1 JAL -> branch_cnt=5, taken_cnt=3. Macro undefined -> both read 0.

Source files
------------

// File: rtl/next_pc_unit.sv
// ---------------------------------------------------------------------------
// next_pc_unit
//   Owns the program counter of the single-issue core. It decodes the
//   instruction in execute and resolves the six RV32I conditional branches
//   plus JAL/JALR against the ALU compare flags and rs1. It computes the next
//   PC, raises a one-cycle flush on every accepted redirect, and enters a
//   sticky trap (PC frozen) when a taken target violates the alignment rule.
//
// Parameters
//   XLEN          datapath / PC width (32 or 64)
//   RESET_VECTOR  PC value loaded on reset
//   IALIGN        instruction alignment in bits (32: target[1:0]==0,
//                 16: target[0]==0)
//
// Ports
//   clk         in   core clock, rising edge
//   rst         in   synchronous active-high reset (priority over en)
//   en          in   1 = advance this cycle, 0 = stall
//   instr       in   instruction in execute (32 bits)
//   zero/lt/ltu in   ALU flags: rs1==rs2, signed rs1<rs2, unsigned rs1<rs2
//   rs1         in   rs1 operand (JALR base)
//   pc          out  current PC (registered)
//   pc_plus4    out  pc + 4, wrapping (link value)
//   taken       out  combinational: current instr redirects control flow
//   flush       out  registered one-cycle pulse after an accepted redirect
//   misaligned  out  sticky trap flag
//   branch_cnt  out  conditional branches retired
//   taken_cnt   out  conditional branches taken
//
// Optional feature
//   NEXT_PC_STATS_EN  when defined, branch_cnt/taken_cnt are live 32-bit
//                     wrapping counters; otherwise both ports are tied to 0
//                     and no counter flops exist.
// ---------------------------------------------------------------------------
module next_pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter int              IALIGN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [31:0]     instr,
    input  logic            zero,
    input  logic            lt,
    input  logic            ltu,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            taken,
    output logic            flush,
    output logic            misaligned,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     taken_cnt
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_nxt_s;
    logic            flush_r;
    logic            flush_nxt_s;
    logic            mis_r;
    logic            mis_nxt_s;

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [XLEN-1:0] imm_b_s;
    logic [XLEN-1:0] imm_j_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] jalr_sum_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] target_s;
    logic            taken_s;
    logic            is_branch_s;
    logic            bad_target_s;

    // Alignment rule for a redirect target.
    function automatic logic misaligned_f(input logic [XLEN-1:0] t);
        logic bad;
        if (IALIGN == 16) begin
            bad = t[0];
        end else begin
            bad = |t[1:0];
        end
        return bad;
    endfunction

    assign opcode_s   = instr[6:0];
    assign funct3_s   = instr[14:12];
    assign imm_b_s    = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
    assign imm_j_s    = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
    assign imm_i_s    = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign jalr_sum_s = rs1 + imm_i_s;
    assign pc_plus4_s = pc_r + PC_STEP;

    // Decode: branch condition, redirect target and whether it is a branch.
    always_comb begin
        taken_s     = 1'b0;
        is_branch_s = 1'b0;
        target_s    = pc_r + imm_b_s;
        case (opcode_s)
            OP_BRANCH: begin
                is_branch_s = 1'b1;
                case (funct3_s)
                    3'b000:  taken_s = zero;
                    3'b001:  taken_s = !zero;
                    3'b100:  taken_s = lt;
                    3'b101:  taken_s = !lt;
                    3'b110:  taken_s = ltu;
                    3'b111:  taken_s = !ltu;
                    default: taken_s = 1'b0;
                endcase
            end
            OP_JAL: begin
                taken_s  = 1'b1;
                target_s = pc_r + imm_j_s;
            end
            OP_JALR: begin
                taken_s  = 1'b1;
                target_s = jalr_sum_s & JALR_MASK;
            end
            default: begin
                taken_s = 1'b0;
            end
        endcase
    end

    // A not-taken branch never traps, whatever its target would have been.
    assign bad_target_s = taken_s && misaligned_f(target_s);

    // RUN/TRAP next-state and next register values.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        flush_nxt_s = 1'b0;
        mis_nxt_s   = mis_r;
        case (state_r)
            ST_RUN: begin
                if (en) begin
                    if (taken_s) begin
                        if (bad_target_s) begin
                            mis_nxt_s   = 1'b1;
                            state_nxt_s = ST_TRAP;
                        end else begin
                            pc_nxt_s    = target_s;
                            flush_nxt_s = 1'b1;
                        end
                    end else begin
                        pc_nxt_s = pc_plus4_s;
                    end
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_TRAP: begin
                mis_nxt_s = 1'b1;
            end
            default: begin
                state_nxt_s = ST_TRAP;
                mis_nxt_s   = 1'b1;
            end
        endcase
    end

    // State, PC, flush and trap flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
            pc_r    <= RESET_VECTOR;
            flush_r <= 1'b0;
            mis_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            flush_r <= flush_nxt_s;
            mis_r   <= mis_nxt_s;
        end
    end

`ifdef NEXT_PC_STATS_EN
    logic [31:0] branch_cnt_r;
    logic [31:0] taken_cnt_r;

    // Conditional-branch statistics; only accepted RUN cycles count.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_r <= 32'd0;
            taken_cnt_r  <= 32'd0;
        end else if (en && (state_r == ST_RUN) && is_branch_s) begin
            branch_cnt_r <= branch_cnt_r + 32'd1;
            if (taken_s) begin
                taken_cnt_r <= taken_cnt_r + 32'd1;
            end else begin
                taken_cnt_r <= taken_cnt_r;
            end
        end else begin
            branch_cnt_r <= branch_cnt_r;
            taken_cnt_r  <= taken_cnt_r;
        end
    end

    assign branch_cnt = branch_cnt_r;
    assign taken_cnt  = taken_cnt_r;
`else
    assign branch_cnt = 32'd0;
    assign taken_cnt  = 32'd0;
`endif

    assign pc         = pc_r;
    assign pc_plus4   = pc_plus4_s;
    assign taken      = taken_s;
    assign flush      = flush_r;
    assign misaligned = mis_r;

endmodule

// File: tb/tb_next_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_next_pc_unit
//   Scoreboard bench for next_pc_unit. Two instances share the stimulus:
//   u_dut with IALIGN=32 and u_dut16 with IALIGN=16, both RESET_VECTOR=0x100.
//   Each directed vector pushes its hand-computed expectation (combinational
//   taken/pc_plus4 before the edge, registered state after it) into a queue;
//   a monitor pops and compares once the matching clock edge has happened.
// ---------------------------------------------------------------------------
module tb_next_pc_unit;

    localparam logic [31:0] ADDI    = 32'h00000013;
    localparam logic [31:0] JR      = 32'h00008067; // jalr x0, 0(x1)
    localparam logic [31:0] JALR_P2 = 32'h00208067; // jalr x0, 2(x1)
    localparam logic [31:0] BEQ_M8  = 32'hFE000CE3;
    localparam logic [31:0] BNE_M8  = 32'hFE001CE3;
    localparam logic [31:0] BLT_16  = 32'h00004863;
    localparam logic [31:0] BGE_16  = 32'h00005863;
    localparam logic [31:0] BLTU_16 = 32'h00006863;
    localparam logic [31:0] BGEU_16 = 32'h00007863;
    localparam logic [31:0] B010_16 = 32'h00002863;
    localparam logic [31:0] JAL_8   = 32'h0080006F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [31:0] instr = 32'h00000013;
    logic        zero = 1'b0;
    logic        lt = 1'b0;
    logic        ltu = 1'b0;
    logic [31:0] rs1 = 32'h0;

    logic [31:0] pc, pc_plus4, branch_cnt, taken_cnt;
    logic        taken, flush, misaligned;
    logic [31:0] pc16, pc_plus4_16, branch_cnt16, taken_cnt16;
    logic        taken16, flush16, misaligned16;

    next_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .IALIGN(32)) u_dut (
        .clk(clk), .rst(rst), .en(en), .instr(instr), .zero(zero), .lt(lt),
        .ltu(ltu), .rs1(rs1), .pc(pc), .pc_plus4(pc_plus4), .taken(taken),
        .flush(flush), .misaligned(misaligned), .branch_cnt(branch_cnt),
        .taken_cnt(taken_cnt));

    next_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .IALIGN(16)) u_dut16 (
        .clk(clk), .rst(rst), .en(en), .instr(instr), .zero(zero), .lt(lt),
        .ltu(ltu), .rs1(rs1), .pc(pc16), .pc_plus4(pc_plus4_16),
        .taken(taken16), .flush(flush16), .misaligned(misaligned16),
        .branch_cnt(branch_cnt16), .taken_cnt(taken_cnt16));

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic        chk_comb;
        logic        taken;
        logic [31:0] ppc4;
        logic [31:0] pc;
        logic        flush;
        logic        mis;
        logic [31:0] pc16;
        logic        flush16;
        logic [31:0] bcnt;
        logic [31:0] tcnt;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_b = 32'd0;
    logic [31:0] exp_t_cnt = 32'd0;
    logic        smp_taken;
    logic [31:0] smp_ppc4;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational outputs are captured mid-cycle, while inputs are stable.
    always @(negedge clk) begin
        smp_taken = taken;
        smp_ppc4  = pc_plus4;
    end

    task automatic cmp(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compares the record belonging to the edge just taken.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                e = sb_q.pop_front();
                if (e.chk_comb) begin
                    cmp(e.name, "taken", {31'd0, smp_taken}, {31'd0, e.taken});
                    cmp(e.name, "pc_plus4", smp_ppc4, e.ppc4);
                end
                cmp(e.name, "pc", pc, e.pc);
                cmp(e.name, "flush", {31'd0, flush}, {31'd0, e.flush});
                cmp(e.name, "misaligned", {31'd0, misaligned}, {31'd0, e.mis});
                cmp(e.name, "pc16", pc16, e.pc16);
                cmp(e.name, "flush16", {31'd0, flush16}, {31'd0, e.flush16});
                cmp(e.name, "misaligned16", {31'd0, misaligned16}, 32'd0);
                cmp(e.name, "branch_cnt", branch_cnt, e.bcnt);
                cmp(e.name, "taken_cnt", taken_cnt, e.tcnt);
            end
        end
    end

    // Drive one cycle of inputs and queue what must be seen after the edge.
    task automatic step(input logic r, input logic e, input logic [31:0] ins,
                        input logic z, input logic l, input logic lu,
                        input logic [31:0] r1, input logic chk,
                        input logic tk, input logic [31:0] ppc4,
                        input logic [31:0] pc_e, input logic fl,
                        input logic mis, input logic [31:0] pc16_e,
                        input logic fl16, input logic cb, input logic ct,
                        input string nm);
        exp_t rec;
        rst = r; en = e; instr = ins; zero = z; lt = l; ltu = lu; rs1 = r1;
`ifdef NEXT_PC_STATS_EN
        if (r) begin
            exp_b = 32'd0;
            exp_t_cnt = 32'd0;
        end else begin
            exp_b = exp_b + {31'd0, cb};
            exp_t_cnt = exp_t_cnt + {31'd0, ct};
        end
`endif
        rec.cyc = cyc + 1; rec.name = nm; rec.chk_comb = chk;
        rec.taken = tk; rec.ppc4 = ppc4; rec.pc = pc_e; rec.flush = fl;
        rec.mis = mis; rec.pc16 = pc16_e; rec.flush16 = fl16;
        rec.bcnt = exp_b; rec.tcnt = exp_t_cnt;
        sb_q.push_back(rec);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        //    r e instr    z l lu rs1           chk tk ppc4          pc            fl mis pc16          f16 cb ct name
        step(1,0,ADDI,    0,0,0, 32'h0,        0,0, 32'h0,        32'h100,      0,0, 32'h100,      0, 0,0, "reset0");
        step(1,1,ADDI,    0,0,0, 32'h0,        0,0, 32'h0,        32'h100,      0,0, 32'h100,      0, 0,0, "reset1");
        step(0,1,ADDI,    0,0,0, 32'h0,        1,0, 32'h104,      32'h104,      0,0, 32'h104,      0, 0,0, "seq1");
        step(0,1,ADDI,    0,0,0, 32'h0,        1,0, 32'h108,      32'h108,      0,0, 32'h108,      0, 0,0, "seq2");
        step(0,1,JR,      0,0,0, 32'h200,      1,1, 32'h10C,      32'h200,      1,0, 32'h200,      1, 0,0, "jr200");
        step(0,1,BEQ_M8,  1,0,0, 32'h0,        1,1, 32'h204,      32'h1F8,      1,0, 32'h1F8,      1, 1,1, "beq_t");
        step(0,1,JR,      0,0,0, 32'h200,      1,1, 32'h1FC,      32'h200,      1,0, 32'h200,      1, 0,0, "jr200b");
        step(0,1,BEQ_M8,  0,0,0, 32'h0,        1,0, 32'h204,      32'h204,      0,0, 32'h204,      0, 1,0, "beq_nt");
        step(0,1,JR,      0,0,0, 32'h300,      1,1, 32'h208,      32'h300,      1,0, 32'h300,      1, 0,0, "jr300");
        step(0,1,BLTU_16, 0,0,1, 32'h0,        1,1, 32'h304,      32'h310,      1,0, 32'h310,      1, 1,1, "bltu_t");
        step(0,1,JR,      0,0,0, 32'h300,      1,1, 32'h314,      32'h300,      1,0, 32'h300,      1, 0,0, "jr300b");
        step(0,1,BGE_16,  0,1,0, 32'h0,        1,0, 32'h304,      32'h304,      0,0, 32'h304,      0, 1,0, "bge_nt");
        step(0,1,JR,      0,0,0, 32'h400,      1,1, 32'h308,      32'h400,      1,0, 32'h400,      1, 0,0, "jr400");
        step(0,0,BNE_M8,  0,0,0, 32'h0,        1,1, 32'h404,      32'h400,      0,0, 32'h400,      0, 0,0, "bne_stall");
        step(0,1,BNE_M8,  0,0,0, 32'h0,        1,1, 32'h404,      32'h3F8,      1,0, 32'h3F8,      1, 1,1, "bne_t");
        step(0,1,BLT_16,  0,1,0, 32'h0,        1,1, 32'h3FC,      32'h408,      1,0, 32'h408,      1, 1,1, "blt_t");
        step(0,1,BGEU_16, 0,0,1, 32'h0,        1,0, 32'h40C,      32'h40C,      0,0, 32'h40C,      0, 1,0, "bgeu_nt");
        step(0,1,B010_16, 1,1,1, 32'h0,        1,0, 32'h410,      32'h410,      0,0, 32'h410,      0, 1,0, "f010_nt");
        step(0,1,JAL_8,   0,0,0, 32'h0,        1,1, 32'h414,      32'h418,      1,0, 32'h418,      1, 0,0, "jal8");
        step(0,0,ADDI,    0,0,0, 32'h0,        1,0, 32'h41C,      32'h418,      0,0, 32'h418,      0, 0,0, "stall_flush");
        step(0,1,JR,      0,0,0, 32'hFFFFFFFC, 1,1, 32'h41C,      32'hFFFFFFFC, 1,0, 32'hFFFFFFFC, 1, 0,0, "jr_top");
        step(0,1,ADDI,    0,0,0, 32'h0,        1,0, 32'h0,        32'h0,        0,0, 32'h0,        0, 0,0, "wrap");
        step(0,1,JALR_P2, 0,0,0, 32'h1001,     1,1, 32'h4,        32'h0,        0,1, 32'h1002,     1, 0,0, "jalr_odd");
        step(0,1,ADDI,    0,0,0, 32'h0,        1,0, 32'h4,        32'h0,        0,1, 32'h1006,     0, 0,0, "trap_hold");
        step(0,1,JALR_P2, 0,0,0, 32'h1000,     1,1, 32'h4,        32'h0,        0,1, 32'h1002,     1, 0,0, "trap_jalr");
        step(0,1,BEQ_M8,  1,0,0, 32'h0,        1,1, 32'h4,        32'h0,        0,1, 32'hFFA,      1, 0,0, "trap_beq");
        step(1,1,ADDI,    0,0,0, 32'h0,        0,0, 32'h0,        32'h100,      0,0, 32'h100,      0, 0,0, "reset2");
        step(0,1,ADDI,    0,0,0, 32'h0,        1,0, 32'h104,      32'h104,      0,0, 32'h104,      0, 0,0, "post_rst");
        en = 1'b0;
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge clk);
            #3;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
